// File: rtl/shift_arb_pkg.sv
// Shared definitions for the two-requester shift arbiter: op encodings, FSM states, datapath width.
package shift_arb_pkg;

    localparam int DW = 32;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_RSVD = 2'b10,
        OP_SRA  = 2'b11
    } op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the two requesters, the shift arbiter and the writeback consumer.
interface shift_arbiter_if #(
    parameter int DW    = 32,
    parameter int TAG_W = 4
);
    logic             r0_valid;
    logic             r0_ready;
    logic [DW-1:0]    r0_x;
    logic [31:0]      r0_shift;
    logic [1:0]       r0_op;
    logic [TAG_W-1:0] r0_tag;

    logic             r1_valid;
    logic             r1_ready;
    logic [DW-1:0]    r1_x;
    logic [31:0]      r1_shift;
    logic [1:0]       r1_op;
    logic [TAG_W-1:0] r1_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [TAG_W-1:0] resp_tag;
    logic [DW-1:0]    resp_data;
    logic             resp_err;

    modport master (
        output r0_valid, r0_x, r0_shift, r0_op, r0_tag,
        output r1_valid, r1_x, r1_shift, r1_op, r1_tag,
        output resp_ready,
        input  r0_ready, r1_ready,
        input  resp_valid, resp_id, resp_tag, resp_data, resp_err
    );

    modport slave (
        input  r0_valid, r0_x, r0_shift, r0_op, r0_tag,
        input  r1_valid, r1_x, r1_shift, r1_op, r1_tag,
        input  resp_ready,
        output r0_ready, r1_ready,
        output resp_valid, resp_id, resp_tag, resp_data, resp_err
    );
endinterface

// File: rtl/shift_core.sv
// Combinational 32-bit barrel shifter (SLL/SRL/SRA) using the full 32-bit shift amount.
module shift_core
    import shift_arb_pkg::*;
(
    input  logic [DW-1:0] x,
    input  logic [31:0]   shift,
    input  logic [1:0]    op,
    output logic [DW-1:0] data,
    output logic          err
);
    logic       big;
    logic [4:0] amt;

    // Any bit above [4] means the whole word is shifted out.
    assign big = |shift[31:5];
    assign amt = shift[4:0];

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (op_e'(op))
            OP_SLL:  data = big ? '0 : x << amt;
            OP_SRL:  data = big ? '0 : x >> amt;
            OP_SRA:  data = big ? {DW{x[DW-1]}} : DW'($signed(x) >>> amt);
            default: err  = 1'b1;
        endcase
    end
endmodule

// File: rtl/shift_arbiter.sv
// Two-requester shift arbiter with a one-entry registered response buffer.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; otherwise R0 has fixed priority.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input logic            clk,
    input logic            reset,
    shift_arbiter_if.slave bus
);
    state_e           state, next_state;
    logic             can_accept, gnt0, gnt1, xfer;
    logic [DW-1:0]    sel_x, core_data;
    logic [31:0]      sel_shift;
    logic [1:0]       sel_op;
    logic [TAG_W-1:0] sel_tag;
    logic             core_err;

    logic             resp_id;
    logic [TAG_W-1:0] resp_tag;
    logic [DW-1:0]    resp_data;
    logic             resp_err;

`ifdef SHIFT_ARB_RR_EN
    logic rr_last;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        gnt0 = bus.r0_valid;
        gnt1 = bus.r1_valid;
        if (bus.r0_valid && bus.r1_valid) begin
            gnt0 = rr_last;
            gnt1 = !rr_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)     rr_last <= 1'b1;
        else if (xfer) rr_last <= bus.r1_ready;
    end
`else
    always_comb begin
        gnt0 = bus.r0_valid;
        gnt1 = bus.r1_valid && !bus.r0_valid;
    end
`endif

    // A held result blocks new grants until the consumer drains it.
    assign can_accept   = (state == EMPTY) || bus.resp_ready;
    assign bus.r0_ready = can_accept && gnt0;
    assign bus.r1_ready = can_accept && gnt1;
    assign xfer         = bus.r0_ready || bus.r1_ready;

    always_comb begin
        sel_x     = bus.r0_x;
        sel_shift = bus.r0_shift;
        sel_op    = bus.r0_op;
        sel_tag   = bus.r0_tag;
        if (bus.r1_ready) begin
            sel_x     = bus.r1_x;
            sel_shift = bus.r1_shift;
            sel_op    = bus.r1_op;
            sel_tag   = bus.r1_tag;
        end
    end

    shift_core u_core (
        .x     (sel_x),
        .shift (sel_shift),
        .op    (sel_op),
        .data  (core_data),
        .err   (core_err)
    );

    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   if (xfer) next_state = FULL;
            FULL:    if (bus.resp_ready && !xfer) next_state = EMPTY;
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_id   <= 1'b0;
            resp_tag  <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else if (xfer) begin
            resp_id   <= bus.r1_ready;
            resp_tag  <= sel_tag;
            resp_data <= core_data;
            resp_err  <= core_err;
        end
    end

    assign bus.resp_valid = (state == FULL);
    assign bus.resp_id    = resp_id;
    assign bus.resp_tag   = resp_tag;
    assign bus.resp_data  = resp_data;
    assign bus.resp_err   = resp_err;
endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: directed requests queue expected responses, a monitor checks them in order.
module tb_shift_arbiter;
    import shift_arb_pkg::*;

    localparam int TW = 4;

    typedef struct {
        logic [31:0]   x;
        logic [31:0]   sh;
        logic [1:0]    op;
        logic [TW-1:0] tag;
    } req_t;

    typedef struct {
        logic          id;
        logic [TW-1:0] tag;
        logic [31:0]   data;
        logic          err;
    } rsp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_arbiter_if #(.DW(DW), .TAG_W(TW)) bus ();

    shift_arbiter #(.TAG_W(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    req_t rq0[$];
    req_t rq1[$];
    rsp_t exp_q[$];
    int   pop_cyc[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic acc0 = 1'b0, acc1 = 1'b0, prev_acc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic add_req(input int who, input logic [31:0] x, input logic [31:0] sh,
                           input logic [1:0] op, input logic [TW-1:0] tag);
        req_t r;
        r.x = x; r.sh = sh; r.op = op; r.tag = tag;
        if (who == 0) rq0.push_back(r);
        else          rq1.push_back(r);
    endtask

    task automatic add_exp(input logic id, input logic [TW-1:0] tag, input logic [31:0] data, input logic err);
        rsp_t e;
        e.id = id; e.tag = tag; e.data = data; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || rq0.size() != 0 || rq1.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            rq0.delete();
            rq1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (bus.resp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_valid_timeout: got resp_valid=%b expected 1", bus.resp_valid);
        end
    endtask

    // Requester driver: presents each queue head, retires it after an observed handshake.
    initial begin
        bus.r0_valid = 1'b0; bus.r0_x = '0; bus.r0_shift = '0; bus.r0_op = '0; bus.r0_tag = '0;
        bus.r1_valid = 1'b0; bus.r1_x = '0; bus.r1_shift = '0; bus.r1_op = '0; bus.r1_tag = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (acc0 && rq0.size() != 0) void'(rq0.pop_front());
            if (acc1 && rq1.size() != 0) void'(rq1.pop_front());
            bus.r0_valid = (rq0.size() != 0);
            if (rq0.size() != 0) begin
                bus.r0_x = rq0[0].x; bus.r0_shift = rq0[0].sh; bus.r0_op = rq0[0].op; bus.r0_tag = rq0[0].tag;
            end
            bus.r1_valid = (rq1.size() != 0);
            if (rq1.size() != 0) begin
                bus.r1_x = rq1[0].x; bus.r1_shift = rq1[0].sh; bus.r1_op = rq1[0].op; bus.r1_tag = rq1[0].tag;
            end
        end
    end

    // Monitor: handshakes, one-cycle latency, grant exclusivity, response scoreboard.
    always @(negedge clk) begin
        rsp_t e;
        acc0 = bus.r0_valid & bus.r0_ready;
        acc1 = bus.r1_valid & bus.r1_ready;
        if (prev_acc) chk("latency_resp_valid", 32'(bus.resp_valid), 32'd1);
        prev_acc = (acc0 | acc1) & !reset;
        if (!reset) begin
            chk("single_grant", 32'(bus.r0_ready & bus.r1_ready), 32'd0);
`ifndef SHIFT_ARB_RR_EN
            if (bus.r0_valid) chk("fixed_prio_r1_ready", 32'(bus.r1_ready), 32'd0);
`endif
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got data %h expected none", bus.resp_data);
                end else begin
                    e = exp_q.pop_front();
                    pop_cyc.push_back(cyc);
                    chk("resp_id",   32'(bus.resp_id),  32'(e.id));
                    chk("resp_tag",  32'(bus.resp_tag), 32'(e.tag));
                    chk("resp_data", bus.resp_data,     e.data);
                    chk("resp_err",  32'(bus.resp_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data",  bus.resp_data,       32'd0);
        chk("rst_resp_tag",   32'(bus.resp_tag),   32'd0);
        chk("rst_resp_id",    32'(bus.resp_id),    32'd0);
        chk("rst_resp_err",   32'(bus.resp_err),   32'd0);

        // Single R0 requests
        add_req(0, 32'h0000_0001, 32'd2, OP_SRL, 4'd1); add_exp(1'b0, 4'd1, 32'h0000_0000, 1'b0);
        add_req(0, 32'h0000_0001, 32'd0, OP_SLL, 4'd2); add_exp(1'b0, 4'd2, 32'h0000_0001, 1'b0);
        drain();

        // R1 boundary shifts, including amounts above 31 carried only in the upper bits
        add_req(1, 32'h8000_0000, 32'd31,        OP_SRA, 4'd3); add_exp(1'b1, 4'd3, 32'hFFFF_FFFF, 1'b0);
        add_req(1, 32'h8000_0000, 32'd32,        OP_SRA, 4'd4); add_exp(1'b1, 4'd4, 32'hFFFF_FFFF, 1'b0);
        add_req(1, 32'h8000_0000, 32'd32,        OP_SRL, 4'd5); add_exp(1'b1, 4'd5, 32'h0000_0000, 1'b0);
        add_req(1, 32'h0000_0001, 32'h0000_0100, OP_SLL, 4'd6); add_exp(1'b1, 4'd6, 32'h0000_0000, 1'b0);
        add_req(1, 32'hF000_0000, 32'd4,         OP_SRA, 4'd7); add_exp(1'b1, 4'd7, 32'hFF00_0000, 1'b0);
        add_req(1, 32'h8000_0000, 32'd31,        OP_SRL, 4'd8); add_exp(1'b1, 4'd8, 32'h0000_0001, 1'b0);
        drain();

        // Both requesters busy: contention order and one result per cycle
        pop_cyc.delete();
        for (int k = 0; k < 4; k++) begin
            add_req(0, 32'(k + 1),    32'(k), OP_SLL, 4'(k));
            add_req(1, 32'h0000_0100, 32'(k), OP_SRL, 4'(8 + k));
        end
`ifdef SHIFT_ARB_RR_EN
        add_exp(1'b0, 4'd0, 32'h0000_0001, 1'b0); add_exp(1'b1, 4'd8,  32'h0000_0100, 1'b0);
        add_exp(1'b0, 4'd1, 32'h0000_0004, 1'b0); add_exp(1'b1, 4'd9,  32'h0000_0080, 1'b0);
        add_exp(1'b0, 4'd2, 32'h0000_000C, 1'b0); add_exp(1'b1, 4'd10, 32'h0000_0040, 1'b0);
        add_exp(1'b0, 4'd3, 32'h0000_0020, 1'b0); add_exp(1'b1, 4'd11, 32'h0000_0020, 1'b0);
`else
        add_exp(1'b0, 4'd0, 32'h0000_0001, 1'b0); add_exp(1'b0, 4'd1,  32'h0000_0004, 1'b0);
        add_exp(1'b0, 4'd2, 32'h0000_000C, 1'b0); add_exp(1'b0, 4'd3,  32'h0000_0020, 1'b0);
        add_exp(1'b1, 4'd8, 32'h0000_0100, 1'b0); add_exp(1'b1, 4'd9,  32'h0000_0080, 1'b0);
        add_exp(1'b1, 4'd10, 32'h0000_0040, 1'b0); add_exp(1'b1, 4'd11, 32'h0000_0020, 1'b0);
`endif
        drain();
        chk("burst_count", 32'(pop_cyc.size()), 32'd8);
        if (pop_cyc.size() == 8) chk("burst_throughput", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

        // Back-pressure: held result stays stable, no grants, grant resumes on release
        @(posedge clk); #1 bus.resp_ready = 1'b0;
        add_req(0, 32'h0000_A5A5, 32'd0, OP_SLL, 4'd9); add_exp(1'b0, 4'd9, 32'h0000_A5A5, 1'b0);
        wait_valid();
        add_req(1, 32'h0000_0010, 32'd1, OP_SLL, 4'd10); add_exp(1'b1, 4'd10, 32'h0000_0020, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid",    32'(bus.resp_valid), 32'd1);
            chk("stall_data",     bus.resp_data,       32'h0000_A5A5);
            chk("stall_tag",      32'(bus.resp_tag),   32'd9);
            chk("stall_id",       32'(bus.resp_id),    32'd0);
            chk("stall_r0_ready", 32'(bus.r0_ready),   32'd0);
            chk("stall_r1_ready", 32'(bus.r1_ready),   32'd0);
        end
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("release_grant", 32'(bus.r1_ready), 32'd1);
        drain();

        // Reserved op consumes a slot and flags an error; next op is clean
        add_req(0, 32'h1234_5678, 32'd0, OP_RSVD, 4'd11); add_exp(1'b0, 4'd11, 32'h0000_0000, 1'b1);
        add_req(0, 32'h5555_5555, 32'd1, OP_SLL,  4'd12); add_exp(1'b0, 4'd12, 32'hAAAA_AAAA, 1'b0);
        drain();

        // Reset while a result is held discards it
        @(posedge clk); #1 bus.resp_ready = 1'b0;
        add_req(0, 32'h0000_DEAD, 32'd0, OP_SLL, 4'd13);
        wait_valid();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("midrst_resp_data",  bus.resp_data,       32'd0);
        chk("midrst_resp_tag",   32'(bus.resp_tag),   32'd0);
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        add_req(0, 32'h0000_0003, 32'd1, OP_SLL, 4'd14); add_exp(1'b0, 4'd14, 32'h0000_0006, 1'b0);
        add_req(1, 32'h0000_0003, 32'd1, OP_SRL, 4'd15); add_exp(1'b1, 4'd15, 32'h0000_0001, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
